integral_image_builder: RTL and testbench
=========================================

INTEGRAL_IMAGE_BUILDER -- requirements
Module: integral_image_builder

Interface
REQ-001 Parameter IMG_W, default 160: pixels per row.
REQ-002 Parameter IMG_H, default 120: rows per frame.
REQ-003 Parameter PIX_W, default 4: greyscale pixel width in bits.
REQ-004 Parameter SQ_EN, default 0: 1 enables the squared-integral output channel.
REQ-005 Derived constants: AW = clog2(IMG_W*IMG_H); IIW = PIX_W + clog2(IMG_W*IMG_H); SQW = 2*PIX_W + clog2(IMG_W*IMG_H).
REQ-006 pclk  in  1  sole clock; all logic on rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 vsync  in  1  frame marker; high = between frames, clears frame state.
REQ-009 pix_valid  in  1  one greyscale pixel present this cycle, raster order.
REQ-010 pix_data  in  PIX_W  pixel value, unsigned.
REQ-011 ii_we  out  1  write strobe for ii_addr/ii_data/ii_sq_data.
REQ-012 ii_addr  out  AW  linear address row*IMG_W+col.
REQ-013 ii_data  out  IIW  integral value at (col,row).
REQ-014 ii_sq_data  out  SQW  squared-integral value; constant 0 when SQ_EN=0.
REQ-015 frame_done  out  1  one-cycle pulse after the last pixel of a frame is written.
REQ-016 busy  out  1  high from first accepted pixel until frame_done.
REQ-017 overrun  out  1  sticky; pixel received while in DONE.

Function
REQ-018 ii(c,r) SHALL equal the sum of pix_data over all (x<=c, y<=r); ii_sq likewise with pix_data squared.
REQ-019 FSM states: IDLE, ACTIVE, DONE; reset and vsync=1 force IDLE from any state.
REQ-020 IDLE->ACTIVE on first pix_valid with vsync=0; that pixel is processed as (0,0).
REQ-021 ACTIVE->DONE on the cycle the pixel (IMG_W-1, IMG_H-1) is accepted.
REQ-022 DONE->IDLE only on vsync=1; pix_valid in DONE ignored, sets overrun.
REQ-023 Latency: ii_we, ii_addr, ii_data, ii_sq_data registered, valid exactly 1 cycle after the accepted pix_valid; ii_we low otherwise.
REQ-024 Per pixel: row_sum <= (col==0 ? 0 : row_sum) + pix; ii = row_sum_next + above, where above = 0 on row 0 else line-buffer entry at col.
REQ-025 Line buffer holds previous-row ii values, depth IMG_W; read and write same column same cycle, read returns old value.
REQ-026 Column counter wraps IMG_W-1 -> 0 and increments row; ii_addr increments by 1 per write, starting at 0.
REQ-027 frame_done asserts in the cycle after the final ii_we (2 cycles after last pix_valid); busy falls same cycle.
REQ-028 No arithmetic overflow: IIW/SQW sized for all-max-pixel frame; all sums unsigned, zero-extended.
REQ-029 vsync=1 mid-frame aborts: counters, row_sum cleared, no frame_done, overrun cleared, pending ii_we of previous cycle still issued.
REQ-030 Gaps in pix_valid SHALL not alter results; state holds.

Reset
REQ-031 rst=1 clears: FSM IDLE, counters, row_sum, ii_we=0, ii_addr=0, ii_data=0, ii_sq_data=0, frame_done=0, busy=0, overrun=0.
REQ-032 Line-buffer contents need not be cleared; row-0 masking guarantees correctness.
REQ-033 rst takes priority over vsync and pix_valid.

Structure
REQ-034 Shared package ii_pkg holds clog2 function and FSM state encodings.
REQ-035 One sub-module ii_line_buf (parametrised depth/width, single-clock read-before-write RAM, BRAM-inferable); instantiated twice when SQ_EN=1.

Verification
REQ-036 IMG_W=4,IMG_H=3, all pixels 1 -> ii_data row-major 1,2,3,4,2,4,6,8,3,6,9,12; frame_done once.
REQ-037 Default params, all pixels 15 -> last write addr 19199, ii_data 288000, no overflow.
REQ-038 IMG_W=4,IMG_H=3,SQ_EN=1, all pixels 3 -> final ii_data 36, ii_sq_data 108.
REQ-039 vsync pulse after 5 pixels, then full 4x3 frame of 2s -> addresses restart at 0, final ii_data 24.
REQ-040 Extra pix_valid after last pixel -> overrun=1, no ii_we; vsync clears it.
REQ-041 rst mid-frame then clean frame with random pix_valid gaps -> outputs match software model.

Source files
------------

// File: rtl/ii_pkg.sv
// Shared definitions for the integral image builder: FSM state encoding
// and the ceiling-log2 helper used to size addresses and accumulators.
package ii_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } ii_state_e;

  // Bits needed to address 'value' distinct locations (clog2(1) = 0).
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 32; i++) begin
      if (((value - 1) >> i) != 0) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/ii_line_buf.sv
// Previous-row line buffer: simple dual-port RAM with one write port and one
// registered read port, read-before-write when both ports hit the same entry.
module ii_line_buf
  import ii_pkg::*;
#(
  parameter int DEPTH = 160,
  parameter int WIDTH = 16,
  localparam int ABW = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ABW-1:0]   waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [ABW-1:0]   raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/integral_image_builder.sv
// Streams a raster-order greyscale frame and writes its integral image (and
// optionally the squared-pixel integral) one entry per accepted pixel.
module integral_image_builder
  import ii_pkg::*;
#(
  parameter int IMG_W = 160,
  parameter int IMG_H = 120,
  parameter int PIX_W = 4,
  parameter int SQ_EN = 0,
  localparam int AW  = clog2(IMG_W * IMG_H),
  localparam int IIW = PIX_W + AW,
  localparam int SQW = 2 * PIX_W + AW
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             vsync,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_data,
  output logic             ii_we,
  output logic [AW-1:0]    ii_addr,
  output logic [IIW-1:0]   ii_data,
  output logic [SQW-1:0]   ii_sq_data,
  output logic             frame_done,
  output logic             busy,
  output logic             overrun,
  output ii_state_e        state
);

  localparam int CW = (clog2(IMG_W) > 0) ? clog2(IMG_W) : 1;
  localparam int RW = (clog2(IMG_H) > 0) ? clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  ii_state_e      state_q, state_d;
  logic [CW-1:0]  col, col_next;
  logic [RW-1:0]  row;
  logic [AW-1:0]  pix_cnt;
  logic           accept, is_last, last_acc;
  logic [IIW-1:0] row_sum, row_sum_next, above, ii_next, lb_rdata;

  assign state = state_q;

  // pix_valid is a push-only strobe with no back-pressure: a pixel is taken
  // whenever pix_valid=1, vsync=0 and the frame is not yet DONE; otherwise it
  // is dropped (and flagged as overrun when it arrives in DONE).
  assign accept  = pix_valid && !vsync && (state_q != ST_DONE);
  assign is_last = (col == COL_LAST) && (row == ROW_LAST);

  always_comb begin
    state_d = state_q;
    if (vsync) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_ACTIVE: if (accept) state_d = is_last ? ST_DONE : ST_ACTIVE;
        ST_DONE:            state_d = ST_DONE;
        default:            state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // The RAM read port is aimed at the column the next pixel will use, so the
  // registered read data is already in place when that pixel arrives.
  always_comb begin
    col_next = col;
    if (vsync)       col_next = '0;
    else if (accept) col_next = (col == COL_LAST) ? '0 : col + CW'(1);
  end

  assign row_sum_next = ((col == '0) ? '0 : row_sum) + IIW'(pix_data);
  assign above        = (row == '0) ? '0 : lb_rdata;
  assign ii_next      = row_sum_next + above;

  ii_line_buf #(.DEPTH(IMG_W), .WIDTH(IIW)) u_ii_buf (
    .clk   (pclk),
    .we    (accept),
    .waddr (col),
    .wdata (ii_next),
    .raddr (col_next),
    .rdata (lb_rdata)
  );

  always_ff @(posedge pclk) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      pix_cnt    <= '0;
      row_sum    <= '0;
      ii_we      <= 1'b0;
      ii_addr    <= '0;
      ii_data    <= '0;
      last_acc   <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      ii_we      <= accept;
      last_acc   <= accept && is_last;
      frame_done <= last_acc;
      col        <= col_next;
      if (accept) begin
        ii_addr <= pix_cnt;
        ii_data <= ii_next;
      end
      if (vsync) begin
        row     <= '0;
        pix_cnt <= '0;
        row_sum <= '0;
        busy    <= 1'b0;
        overrun <= 1'b0;
      end else begin
        if (accept) begin
          row_sum <= row_sum_next;
          pix_cnt <= is_last ? '0 : pix_cnt + AW'(1);
          if (col == COL_LAST) row <= is_last ? '0 : row + RW'(1);
        end
        if (last_acc)    busy <= 1'b0;
        else if (accept) busy <= 1'b1;
        if (state_q == ST_DONE && pix_valid) overrun <= 1'b1;
      end
    end
  end

  generate
    if (SQ_EN != 0) begin : g_sq
      logic [SQW-1:0] sq_row_sum, sq_row_sum_next, sq_above, sq_next, sq_rdata, pix_sq;

      assign pix_sq          = SQW'(pix_data) * SQW'(pix_data);
      assign sq_row_sum_next = ((col == '0) ? '0 : sq_row_sum) + pix_sq;
      assign sq_above        = (row == '0) ? '0 : sq_rdata;
      assign sq_next         = sq_row_sum_next + sq_above;

      ii_line_buf #(.DEPTH(IMG_W), .WIDTH(SQW)) u_sq_buf (
        .clk   (pclk),
        .we    (accept),
        .waddr (col),
        .wdata (sq_next),
        .raddr (col_next),
        .rdata (sq_rdata)
      );

      always_ff @(posedge pclk) begin
        if (rst) begin
          sq_row_sum <= '0;
          ii_sq_data <= '0;
        end else begin
          if (vsync)       sq_row_sum <= '0;
          else if (accept) sq_row_sum <= sq_row_sum_next;
          if (accept) ii_sq_data <= sq_next;
        end
      end
    end else begin : g_no_sq
      assign ii_sq_data = '0;
    end
  endgenerate

endmodule

// File: tb/tb_integral_image_builder.sv
// Bench for integral_image_builder: a small 4x3 instance with the squared
// channel and a default-size instance, each checked against a sum model.
module tb_integral_image_builder;
  import ii_pkg::*;

  localparam int A_W = 4, A_H = 3, A_N = A_W * A_H;
  localparam int A_AW = clog2(A_N), A_IIW = 4 + A_AW, A_SQW = 8 + A_AW;
  localparam int A_EW = A_AW + A_IIW + A_SQW;
  localparam int B_W = 160, B_H = 120, B_N = B_W * B_H;
  localparam int B_AW = clog2(B_N), B_IIW = 4 + B_AW, B_SQW = 8 + B_AW;
  localparam int B_EW = B_AW + B_IIW;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             vsync_a, pix_valid_a, ii_we_a, frame_done_a, busy_a, overrun_a;
  logic [3:0]       pix_data_a;
  logic [A_AW-1:0]  ii_addr_a;
  logic [A_IIW-1:0] ii_data_a;
  logic [A_SQW-1:0] ii_sq_data_a;
  ii_state_e        state_a;

  logic             vsync_b, pix_valid_b, ii_we_b, frame_done_b, busy_b, overrun_b;
  logic [3:0]       pix_data_b;
  logic [B_AW-1:0]  ii_addr_b;
  logic [B_IIW-1:0] ii_data_b;
  logic [B_SQW-1:0] ii_sq_data_b;
  ii_state_e        state_b;

  integral_image_builder #(.IMG_W(A_W), .IMG_H(A_H), .PIX_W(4), .SQ_EN(1)) dut_a (
    .pclk(clk), .rst(rst), .vsync(vsync_a), .pix_valid(pix_valid_a), .pix_data(pix_data_a),
    .ii_we(ii_we_a), .ii_addr(ii_addr_a), .ii_data(ii_data_a), .ii_sq_data(ii_sq_data_a),
    .frame_done(frame_done_a), .busy(busy_a), .overrun(overrun_a), .state(state_a)
  );

  integral_image_builder dut_b (
    .pclk(clk), .rst(rst), .vsync(vsync_b), .pix_valid(pix_valid_b), .pix_data(pix_data_b),
    .ii_we(ii_we_b), .ii_addr(ii_addr_b), .ii_data(ii_data_b), .ii_sq_data(ii_sq_data_b),
    .frame_done(frame_done_b), .busy(busy_b), .overrun(overrun_b), .state(state_b)
  );

  int checks = 0;
  int failures = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // model A: ii by direct summation over the rectangle
  int pa [A_N];
  int ka, ca, ra, sa, qa;
  bit done_a, last_a, fd_a_e, busy_a_e, ov_a_e;
  logic [A_EW-1:0] exp_a_q[$];
  logic [A_EW-1:0] got_a_q[$];
  logic [A_EW-1:0] ea;
  int fd_cnt_a = 0;

  always @(posedge clk) begin
    if (rst) begin
      exp_a_q.delete();
      ka = 0; done_a = 0; last_a = 0; fd_a_e = 0; busy_a_e = 0; ov_a_e = 0;
    end else begin
      fd_a_e = last_a;
      last_a = 0;
      if (fd_a_e) busy_a_e = 0;
      if (vsync_a) begin
        ka = 0; done_a = 0; busy_a_e = 0; ov_a_e = 0;
      end else if (pix_valid_a) begin
        if (done_a) begin
          ov_a_e = 1;
        end else begin
          pa[ka] = int'(pix_data_a);
          ca = ka % A_W; ra = ka / A_W; sa = 0; qa = 0;
          for (int y = 0; y <= ra; y++)
            for (int x = 0; x <= ca; x++) begin
              sa += pa[y*A_W+x];
              qa += pa[y*A_W+x] * pa[y*A_W+x];
            end
          exp_a_q.push_back({A_AW'(ka), A_IIW'(sa), A_SQW'(qa)});
          busy_a_e = 1;
          ka++;
          if (ka == A_N) begin done_a = 1; last_a = 1; end
        end
      end
    end
  end

  // model B: ii by inclusion-exclusion over previously computed entries
  int ib [B_N];
  int kb, cb, rb, vb;
  bit done_b, last_b, fd_b_e, busy_b_e, ov_b_e;
  logic [B_EW-1:0] exp_b_q[$];
  logic [B_EW-1:0] eb;
  int fd_cnt_b = 0, nw_b = 0;
  logic [B_AW-1:0]  b_last_addr;
  logic [B_IIW-1:0] b_last_ii;

  always @(posedge clk) begin
    if (rst) begin
      exp_b_q.delete();
      kb = 0; done_b = 0; last_b = 0; fd_b_e = 0; busy_b_e = 0; ov_b_e = 0;
    end else begin
      fd_b_e = last_b;
      last_b = 0;
      if (fd_b_e) busy_b_e = 0;
      if (vsync_b) begin
        kb = 0; done_b = 0; busy_b_e = 0; ov_b_e = 0;
      end else if (pix_valid_b) begin
        if (done_b) begin
          ov_b_e = 1;
        end else begin
          cb = kb % B_W; rb = kb / B_W; vb = int'(pix_data_b);
          if (cb > 0) vb += ib[kb-1];
          if (rb > 0) vb += ib[kb-B_W];
          if (cb > 0 && rb > 0) vb -= ib[kb-B_W-1];
          ib[kb] = vb;
          exp_b_q.push_back({B_AW'(kb), B_IIW'(vb)});
          busy_b_e = 1;
          kb++;
          if (kb == B_N) begin done_b = 1; last_b = 1; end
        end
      end
    end
  end

  // scoreboard / compare, away from the active edge
  always @(negedge clk) begin
    if (chk_on) begin
      chk("a_we", ii_we_a, exp_a_q.size() != 0);
      if (exp_a_q.size() != 0) begin
        ea = exp_a_q.pop_front();
        if (ii_we_a) begin
          chk("a_addr", ii_addr_a, ea[A_EW-1 -: A_AW]);
          chk("a_ii", ii_data_a, ea[A_IIW+A_SQW-1 -: A_IIW]);
          chk("a_sq", ii_sq_data_a, ea[A_SQW-1:0]);
          got_a_q.push_back({ii_addr_a, ii_data_a, ii_sq_data_a});
        end
      end
      chk("a_frame_done", frame_done_a, fd_a_e);
      chk("a_busy", busy_a, busy_a_e);
      chk("a_overrun", overrun_a, ov_a_e);
      chk("a_state", state_a, done_a ? ST_DONE : (ka > 0 ? ST_ACTIVE : ST_IDLE));
      if (frame_done_a) fd_cnt_a++;

      chk("b_we", ii_we_b, exp_b_q.size() != 0);
      if (exp_b_q.size() != 0) begin
        eb = exp_b_q.pop_front();
        if (ii_we_b) begin
          chk("b_addr", ii_addr_b, eb[B_EW-1 -: B_AW]);
          chk("b_ii", ii_data_b, eb[B_IIW-1:0]);
          b_last_addr = ii_addr_b;
          b_last_ii   = ii_data_b;
          nw_b++;
        end
      end
      chk("b_sq_zero", ii_sq_data_b, 0);
      chk("b_frame_done", frame_done_b, fd_b_e);
      chk("b_busy", busy_b, busy_b_e);
      chk("b_overrun", overrun_b, ov_b_e);
      chk("b_state", state_b, done_b ? ST_DONE : (kb > 0 ? ST_ACTIVE : ST_IDLE));
      if (frame_done_b) fd_cnt_b++;
    end
  end

  // driver tasks
  task automatic step_a(input logic v, input logic [3:0] d, input logic vs);
    pix_valid_a = v; pix_data_a = d; vsync_a = vs;
    @(negedge clk);
  endtask

  task automatic step_b(input logic v, input logic [3:0] d, input logic vs);
    pix_valid_b = v; pix_data_b = d; vsync_b = vs;
    @(negedge clk);
  endtask

  // fixed < 0 selects random pixel values
  task automatic frame_a(input int fixed, input int max_gap, input int npix);
    for (int i = 0; i < npix; i++) begin
      int g;
      g = $urandom_range(max_gap, 0);
      repeat (g) step_a(1'b0, 4'd0, 1'b0);
      step_a(1'b1, (fixed < 0) ? 4'($urandom_range(15, 0)) : 4'(fixed), 1'b0);
    end
    repeat (3) step_a(1'b0, 4'd0, 1'b0);
  endtask

  int t1_lit [12] = '{1, 2, 3, 4, 2, 4, 6, 8, 3, 6, 9, 12};
  int fd_base;
  logic [A_EW-1:0] g;

  initial begin
    rst = 1'b1;
    vsync_a = 1'b1; pix_valid_a = 1'b0; pix_data_a = '0;
    vsync_b = 1'b1; pix_valid_b = 1'b0; pix_data_b = '0;
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    chk("rst_we", ii_we_a, 0);
    chk("rst_addr", ii_addr_a, 0);
    chk("rst_ii", ii_data_a, 0);
    chk("rst_sq", ii_sq_data_a, 0);
    chk("rst_frame_done", frame_done_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_overrun", overrun_a, 0);
    chk("rst_state", state_a, ST_IDLE);
    rst = 1'b0;
    step_a(1'b0, 4'd0, 1'b1);

    // 4x3 frame of ones, back to back
    got_a_q.delete(); fd_base = fd_cnt_a;
    frame_a(1, 0, A_N);
    chk("t1_nwrites", got_a_q.size(), 12);
    for (int i = 0; i < 12 && i < got_a_q.size(); i++) begin
      g = got_a_q[i];
      chk($sformatf("t1_ii[%0d]", i), g[A_IIW+A_SQW-1 -: A_IIW], t1_lit[i]);
    end
    chk("t1_frame_done_cnt", fd_cnt_a - fd_base, 1);

    // frame of threes with gaps
    step_a(1'b0, 4'd0, 1'b1);
    got_a_q.delete();
    frame_a(3, 2, A_N);
    chk("t2_nwrites", got_a_q.size(), 12);
    g = got_a_q[$];
    chk("t2_last_ii", g[A_IIW+A_SQW-1 -: A_IIW], 36);
    chk("t2_last_sq", g[A_SQW-1:0], 108);

    // abort after 5 pixels, then a full frame of twos
    step_a(1'b0, 4'd0, 1'b1);
    fd_base = fd_cnt_a;
    frame_a(-1, 1, 5);
    step_a(1'b0, 4'd0, 1'b1);
    got_a_q.delete();
    frame_a(2, 0, A_N);
    chk("t3_nwrites", got_a_q.size(), 12);
    g = got_a_q[0];
    chk("t3_first_addr", g[A_EW-1 -: A_AW], 0);
    g = got_a_q[$];
    chk("t3_last_addr", g[A_EW-1 -: A_AW], 11);
    chk("t3_last_ii", g[A_IIW+A_SQW-1 -: A_IIW], 24);
    chk("t3_frame_done_cnt", fd_cnt_a - fd_base, 1);

    // extra pixels while DONE
    step_a(1'b1, 4'd5, 1'b0);
    step_a(1'b1, 4'd7, 1'b0);
    step_a(1'b0, 4'd0, 1'b0);
    chk("t4_overrun_set", overrun_a, 1);
    chk("t4_no_write", got_a_q.size(), 12);
    step_a(1'b0, 4'd0, 1'b1);
    chk("t4_overrun_clear", overrun_a, 0);

    // reset mid-frame, then random frames with random gaps
    frame_a(-1, 1, 6);
    rst = 1'b1;
    step_a(1'b0, 4'd0, 1'b0);
    step_a(1'b1, 4'd9, 1'b0);
    rst = 1'b0;
    for (int f = 0; f < 6; f++) begin
      repeat ($urandom_range(3, 1)) step_a(1'b0, 4'd0, 1'b1);
      frame_a(-1, f % 3, A_N);
      if (f == 2) step_a(1'b1, 4'd1, 1'b0);
    end
    step_a(1'b0, 4'd0, 1'b1);

    // default-size frame of all 15s
    step_b(1'b0, 4'd0, 1'b1);
    for (int i = 0; i < B_N; i++) begin
      if ($urandom_range(7, 0) == 0) step_b(1'b0, 4'd0, 1'b0);
      step_b(1'b1, 4'd15, 1'b0);
    end
    repeat (4) step_b(1'b0, 4'd0, 1'b0);
    chk("t6_nwrites", nw_b, B_N);
    chk("t6_last_addr", b_last_addr, 19199);
    chk("t6_last_ii", b_last_ii, 288000);
    chk("t6_frame_done_cnt", fd_cnt_b, 1);
    step_b(1'b0, 4'd0, 1'b1);

    chk("a_queue_drained", exp_a_q.size(), 0);
    chk("b_queue_drained", exp_b_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
